// File: rtl/tx_packet_arbiter.sv
// Round-robin packet arbiter in front of uart_tx: frames each granted source's
// payload as header byte, payload bytes and an XOR checksum trailer.
module tx_packet_arbiter #(
  parameter int unsigned NUM_SRC   = 3,
  parameter logic [3:0]  HDR_MAGIC = 4'hA
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [15:0]            pkt_count
);

  localparam int unsigned IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] GRANT_LSB = NUM_SRC'(1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, FETCH} state_t;
  typedef enum logic [1:0] {HDR, PAYLOAD, TRAILER} phase_t;

  state_t         state;
  phase_t         phase;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic [7:0]     chk;
  logic           last_seen;
  logic [7:0]     g_byte;
  logic           g_valid;
  logic           g_last;

  // First requester strictly after rr_ptr, wrapping; rr_ptr itself comes last.
  always_comb begin : arbitrate
    int unsigned idx;
    idx    = 0;
    winner = rr_ptr;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_SRC;
      if (!found && src_req[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // rr_ptr holds the granted index for the whole packet, so it selects the byte lane.
  always_comb begin : lane_mux
    g_byte  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (rr_ptr == IDW'(k)) begin
        g_byte  = src_data[8*k +: 8];
        g_valid = src_valid[k];
        g_last  = src_last[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      phase     <= HDR;
      rr_ptr    <= IDW'(NUM_SRC - 1);
      chk       <= '0;
      last_seen <= 1'b0;
      src_ready <= '0;
      src_grant <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      tx_start  <= 1'b0;
      src_ready <= '0;
      case (state)
        IDLE: begin
          if (tx_done && found) begin
            src_grant <= GRANT_LSB << winner;
            rr_ptr    <= winner;
            busy      <= 1'b1;
            chk       <= '0;
            last_seen <= 1'b0;
            tx_data   <= {HDR_MAGIC, 1'b0, 3'(winner)};
            phase     <= HDR;
            tx_start  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!tx_done) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (phase == TRAILER) begin
              src_grant <= '0;
              busy      <= 1'b0;
              pkt_count <= pkt_count + 16'd1;
              state     <= IDLE;
            end else if (phase == PAYLOAD && last_seen) begin
              tx_data  <= chk;
              phase    <= TRAILER;
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (g_valid) begin
            src_ready <= src_grant;
            tx_data   <= g_byte;
            chk       <= chk ^ g_byte;
            last_seen <= g_last;
            phase     <= PAYLOAD;
            tx_start  <= 1'b1;
            state     <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Scoreboard bench for tx_packet_arbiter: queued sources, a uart_tx line model
// and a round-robin framing model that predicts every byte on the line.
module tb_tx_packet_arbiter;
  localparam int unsigned N     = 3;
  localparam int unsigned FRAME = 50;
  localparam int unsigned LIMIT = 40000;

  logic           clk       = 1'b0;
  logic           rst_in    = 1'b1;
  logic [N-1:0]   src_req   = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_last  = '0;
  logic [8*N-1:0] src_data  = '0;
  logic [N-1:0]   src_ready;
  logic [N-1:0]   src_grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done   = 1'b1;
  logic           busy;
  logic [15:0]    pkt_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  line_q[$];
  logic [15:0] cnt_q[$];
  logic [8:0]  mem [N][256];
  int unsigned wr [N];
  int unsigned rd [N];
  int unsigned mrd [N];
  int unsigned ready_cnt [N];
  logic [N-1:0] stall_on   = '0;
  logic         drop_req   = 1'b0;
  int unsigned  model_last = N - 1;
  logic [15:0]  model_cnt  = '0;
  int unsigned  u_cnt      = 0;
  logic [7:0]   u_byte     = '0;

  tx_packet_arbiter #(.NUM_SRC(N), .HDR_MAGIC(4'hA)) dut (
    .clk(clk), .rst_in(rst_in), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .src_grant(src_grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // uart_tx stand-in: latches a byte on tx_start, holds tx_done low for one frame.
  always @(posedge clk) begin
    if (u_cnt == 0) begin
      if (tx_start) begin
        u_cnt   <= FRAME;
        u_byte  <= tx_data;
        tx_done <= 1'b0;
      end
    end else if (u_cnt == 1) begin
      u_cnt   <= 0;
      tx_done <= 1'b1;
      line_q.push_back(u_byte);
    end else begin
      u_cnt <= u_cnt - 1;
    end
  end

  initial begin : monitor
    logic       busy_d;
    logic [7:0] b;
    busy_d = 1'b0;
    forever begin
      @(negedge clk);
      while (line_q.size() > 0) begin
        b = line_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL line_byte: got 0x%02h, expected no byte", b);
        end else begin
          check("line_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
      if (src_ready != '0) begin
        check("ready_onehot", 32'($onehot(src_ready)), 32'(1));
        check("ready_granted", 32'(src_ready & ~src_grant), 32'(0));
      end
      if (!rst_in && busy_d && !busy) begin
        check("grant_at_end", 32'(src_grant), 32'(0));
        if (cnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pkt_end: got packet end with count 0x%0h, expected none", pkt_count);
        end else begin
          check("pkt_count", 32'(pkt_count), 32'(cnt_q.pop_front()));
        end
      end
      busy_d = busy;
    end
  end

  // Sources present their current queued byte; a reset abandons whatever is queued.
  initial begin : driver
    logic       pend;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst_in) rd[i] = wr[i];
        else if (src_ready[i]) begin
          rd[i]++;
          ready_cnt[i]++;
        end
        pend = (rd[i] != wr[i]);
        e = mem[i][rd[i] % 256];
        src_req[i]         = pend && !(drop_req && src_grant[i]);
        src_valid[i]       = pend && !stall_on[i] && ($urandom_range(0, 3) != 0);
        src_data[8*i +: 8] = pend ? e[7:0] : 8'($urandom);
        src_last[i]        = pend ? e[8] : 1'($urandom);
      end
    end
  end

  task automatic add_byte(input int unsigned s, input logic [7:0] b, input logic last);
    mem[s][wr[s] % 256] = {last, b};
    wr[s]++;
  endtask

  task automatic add_packet(input int unsigned s, input int unsigned len);
    for (int unsigned j = 0; j < len; j++) add_byte(s, 8'($urandom), j == len - 1);
  endtask

  // Serve all queued packets in round-robin order, framing each one.
  task automatic run_model();
    int unsigned s;
    logic        found;
    logic [7:0]  chk;
    logic [8:0]  e;
    for (int p = 0; p < 256; p++) begin
      found = 1'b0;
      s = 0;
      for (int unsigned k = 1; k <= N; k++) begin
        if (!found && mrd[(model_last + k) % N] != wr[(model_last + k) % N]) begin
          found = 1'b1;
          s = (model_last + k) % N;
        end
      end
      if (!found) break;
      model_last = s;
      exp_q.push_back({4'hA, 1'b0, 3'(s)});
      chk = '0;
      do begin
        e = mem[s][mrd[s] % 256];
        mrd[s]++;
        exp_q.push_back(e[7:0]);
        chk ^= e[7:0];
      end while (!e[8]);
      exp_q.push_back(chk);
      model_cnt++;
      cnt_q.push_back(model_cnt);
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned t = 0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0 || busy) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_timeout"}, 32'(t >= LIMIT), 32'(0));
    if (t >= LIMIT) begin
      exp_q.delete();
      cnt_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done_level(input string name, input logic v);
    int unsigned t = 0;
    while (tx_done !== v && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout, expected tx_done=%0d", name, v);
    end
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] mask);
    int unsigned t = 0;
    while ((src_grant & mask) == '0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout, expected grant 0x%0h", name, mask);
    end
  endtask

  task automatic wait_ready(input string name, input int unsigned s, input int unsigned target);
    int unsigned t = 0;
    while (ready_cnt[s] < target && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout, expected %0d ready pulses", name, target);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'(0));
    check({tag, "_grant"}, 32'(src_grant), 32'(0));
    check({tag, "_ready"}, 32'(src_ready), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'(0));
  endtask

  initial begin : main
    int unsigned r;
    int unsigned bad;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_in = 1'b0;
    @(negedge clk);

    // Single source, fixed payload: line must carry A1 12 34 26.
    r = ready_cnt[1];
    add_byte(1, 8'h12, 1'b0);
    add_byte(1, 8'h34, 1'b1);
    run_model();
    wait_drain("single");
    check("single_ready_pulses", 32'(ready_cnt[1] - r), 32'(2));
    check("single_busy", 32'(busy), 32'(0));
    check("single_count", 32'(pkt_count), 32'(1));

    // All sources continuously requesting with one-byte packets.
    for (int p = 0; p < 3; p++)
      for (int unsigned s = 0; s < N; s++) add_packet(s, 1);
    run_model();
    wait_drain("rr_all");

    // Source 2 withholds valid while its packet sits in FETCH.
    stall_on[2] = 1'b1;
    add_packet(2, 2);
    run_model();
    wait_grant("stall_grant", 3'b100);
    wait_done_level("stall_hdr_start", 1'b0);
    wait_done_level("stall_hdr_end", 1'b1);
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tx_start || src_grant != 3'b100) bad++;
    end
    check("stall_quiet_cycles", 32'(bad), 32'(0));
    stall_on[2] = 1'b0;
    wait_drain("stall");

    // src_req drops while granted; the packet still runs to its last byte.
    drop_req = 1'b1;
    add_packet(0, 3);
    add_packet(1, 1);
    run_model();
    wait_drain("drop_req");
    drop_req = 1'b0;

    for (int round = 0; round < 4; round++) begin
      drop_req = 1'($urandom);
      for (int unsigned s = 0; s < N; s++) begin
        int unsigned np;
        np = $urandom_range(0, 2);
        for (int unsigned k = 0; k < np; k++) add_packet(s, $urandom_range(1, 4));
      end
      run_model();
      wait_drain("random");
    end
    drop_req = 1'b0;

    // Reset while payload byte 2 of 4 is on the line: that byte finishes, nothing else.
    r = ready_cnt[1];
    add_byte(1, 8'h5A, 1'b0);
    add_byte(1, 8'hC3, 1'b0);
    add_byte(1, 8'h0F, 1'b0);
    add_byte(1, 8'hF0, 1'b1);
    mrd[1] = wr[1];
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    wait_ready("reset_ready", 1, r + 2);
    wait_done_level("reset_byte_start", 1'b0);
    #2 rst_in = 1'b1;
    #1 check_zero_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    model_last = N - 1;
    model_cnt = '0;
    @(negedge clk);
    check("post_reset_count", 32'(pkt_count), 32'(0));

    add_packet(1, 2);
    add_packet(0, 1);
    add_packet(2, 1);
    run_model();
    wait_grant("post_reset_grant", '1);
    check("post_reset_first_grant", 32'(src_grant), 32'(1));
    wait_drain("post_reset");

    // Counter wrap from 65535.
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count;
    @(negedge clk);
    check("forced_count", 32'(pkt_count), 32'(16'hFFFF));
    model_cnt = 16'hFFFF;
    add_packet(1, 2);
    run_model();
    wait_drain("wrap");
    check("wrap_count", 32'(pkt_count), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
